// File: rtl/inner_product_pu.sv
// PU side of the read/write stream protocol: pulls num_taps input words per output,
// multiplies every lane by a per-tap weight, accumulates, and writes one result word per output.
module inner_product_pu #(
    parameter int OP_WIDTH   = 16,
    parameter int NUM_PE     = 1,
    parameter int MAX_TAPS   = 64,
    localparam int TAP_W     = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1,
    localparam int DATA_WIDTH = OP_WIDTH * NUM_PE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  w_wr_en,
    input  logic [TAP_W-1:0]      w_wr_addr,
    input  logic [OP_WIDTH-1:0]   w_wr_data,
    input  logic                  start,
    input  logic [TAP_W:0]        num_taps,
    input  logic [15:0]           num_outputs,
    output logic                  pu_rd_req,
    input  logic                  pu_rd_ready,
    input  logic [DATA_WIDTH-1:0] pu_data_in,
    output logic                  pu_wr_req,
    output logic [DATA_WIDTH-1:0] pu_data_out,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [TAP_W-1:0]      tap_k;
    logic [TAP_W:0]        taps_q;
    logic [15:0]           outs_q;
    logic [15:0]           out_cnt;
    logic                  pipe_valid;
    logic [TAP_W-1:0]      pipe_k;
    logic [OP_WIDTH-1:0]   acc     [NUM_PE];
    logic [OP_WIDTH-1:0]   acc_nxt [NUM_PE];
    logic [DATA_WIDTH-1:0] acc_flat;
    logic [OP_WIDTH-1:0]   w_cur;
    logic [OP_WIDTH-1:0]   prod;
    logic                  last_tap;
    logic [OP_WIDTH-1:0]   wbuf [MAX_TAPS];

    // Handshake: pu_rd_req is raised only while pu_rd_ready is high, and each cycle it is high
    // transfers exactly one word, returned on pu_data_in in the following cycle. pu_wr_req is a
    // one-cycle strobe with no backpressure; pu_data_out is meaningful only while it is high.
    assign pu_rd_req = (state == S_REQ) && pu_rd_ready;
    assign dbg_state = state;
    assign last_tap  = ({1'b0, tap_k} == (taps_q - (TAP_W + 1)'(1)));

    // Weights survive reset so a job can be rerun after an abort without reloading.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            wbuf[w_wr_addr] <= w_wr_data;
        end
    end

    // Lane products wrap to OP_WIDTH bits, so signed and unsigned operands give the same result.
    always_comb begin
        w_cur    = wbuf[pipe_k];
        prod     = '0;
        acc_flat = '0;
        for (int j = 0; j < NUM_PE; j++) begin
            acc_nxt[j] = acc[j];
            prod       = pu_data_in[j*OP_WIDTH +: OP_WIDTH] * w_cur;
            if (pipe_valid) begin
                acc_nxt[j] = acc[j] + prod;
            end
            acc_flat[j*OP_WIDTH +: OP_WIDTH] = acc_nxt[j];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tap_k       <= '0;
            taps_q      <= '0;
            outs_q      <= '0;
            out_cnt     <= '0;
            pipe_valid  <= 1'b0;
            pipe_k      <= '0;
            pu_wr_req   <= 1'b0;
            pu_data_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int j = 0; j < NUM_PE; j++) begin
                acc[j] <= '0;
            end
        end else begin
            pipe_valid <= pu_rd_req;
            pipe_k     <= tap_k;
            pu_wr_req  <= 1'b0;
            done       <= 1'b0;
            for (int j = 0; j < NUM_PE; j++) begin
                acc[j] <= acc_nxt[j];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        taps_q  <= num_taps;
                        outs_q  <= num_outputs;
                        tap_k   <= '0;
                        out_cnt <= '0;
                        if ((num_taps != '0) && (num_outputs != '0)) begin
                            state <= S_REQ;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (pu_rd_ready) begin
                        tap_k <= tap_k + 1'b1;
                        if (last_tap) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final word lands in the accumulator this cycle; capture the sum including it.
                    state       <= S_WRITE;
                    pu_wr_req   <= 1'b1;
                    pu_data_out <= acc_flat;
                end
                S_WRITE: begin
                    for (int j = 0; j < NUM_PE; j++) begin
                        acc[j] <= '0;
                    end
                    out_cnt <= out_cnt + 16'd1;
                    tap_k   <= '0;
                    if (out_cnt == (outs_q - 16'd1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inner_product_pu.md
Name: inner_product_pu

Overview:
- Processing-unit side of the PU read/write stream protocol used by the inner-product test environment.
- Issues pu_rd_req pulses to pull NUM_PE-wide input words from the memory/driver side.
- Multiplies each lane by a shared per-tap weight held in a local weight buffer and accumulates over num_taps words.
- Emits one NUM_PE-wide result word per output with a pu_wr_req pulse; repeats num_outputs times per start.

Parameters:
- OP_WIDTH, 16, operand and result width per lane.
- NUM_PE, 1, number of parallel lanes; DATA_WIDTH = OP_WIDTH*NUM_PE.
- MAX_TAPS, 64, weight buffer depth; TAP_W = ceil(log2(MAX_TAPS)).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- w_wr_en  input  1  weight buffer write strobe.
- w_wr_addr  input  TAP_W  weight index.
- w_wr_data  input  OP_WIDTH  weight value.
- start  input  1  one-cycle pulse, begins a job.
- num_taps  input  TAP_W+1  taps per output (0..MAX_TAPS), sampled on start.
- num_outputs  input  16  output words per job, sampled on start.
- pu_rd_req  output  1  read request pulse, one word per asserted cycle.
- pu_rd_ready  input  1  responder has data; requests only issued while high.
- pu_data_in  input  DATA_WIDTH  read data, valid the cycle after pu_rd_req.
- pu_wr_req  output  1  write strobe, one cycle per result word.
- pu_data_out  output  DATA_WIDTH  result word, valid when pu_wr_req is high.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse at end of job.

Behaviour:
- Reset (async, reset_n low): pu_rd_req=0, pu_wr_req=0, pu_data_out=0, busy=0, done=0. Accumulators and counters are cleared; FSM goes to IDLE. The weight buffer is NOT cleared.
- Weight writes are accepted in any state and take effect the next cycle. Writing during a job is legal but gives undefined results.
- FSM states: IDLE, REQ, DRAIN, WRITE, DONE.
- IDLE:
  - start with num_taps>0 and num_outputs>0 -> REQ, busy=1.
  - start with either equal to 0 -> DONE; no reads or writes are issued.
- REQ: pu_rd_req = pu_rd_ready (combinational AND with state).
  - Each cycle with pu_rd_req=1 records tap index k in a 1-stage valid/index pipe, then k++.
  - When the request for k=num_taps-1 is issued -> DRAIN.
  - pu_rd_ready low: hold in REQ, no request, counters frozen.
- Data return: the cycle after a request, each lane j accumulates acc[j] += pu_data_in[j] * w[k].
  - Arithmetic is modulo 2^OP_WIDTH (low OP_WIDTH bits of the product and the sum); signedness is irrelevant.
- DRAIN: one cycle while the last word is accumulated -> WRITE.
- WRITE:
  - pu_wr_req=1 for exactly one cycle; pu_data_out lane j = acc[j].
  - Accumulators clear at the same edge; output counter increments.
  - More outputs remain -> REQ with k=0; else -> DONE.
- pu_data_out holds its last value after WRITE and is only meaningful while pu_wr_req is high.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy is ignored.
- Timing with pu_rd_ready constantly high:
  - Per output: num_taps + 2 cycles.
  - Start sampled at edge 0 gives first pu_rd_req in cycle 1; first pu_wr_req in cycle num_taps+2.
- Reset mid-job aborts immediately. No partial write is emitted after reset, and a new start works normally.

Test Plan:
- NUM_PE=1, weights {1,2,3}, num_taps=3, num_outputs=1, inputs 0,1,2, ready high -> rd_req in cycles 1-3, single pu_wr_req in cycle 5 with data 8, done in cycle 6.
- NUM_PE=2, same weights, lane0 inputs 0,1,2 and lane1 inputs 3,4,5 -> pu_data_out = {26, 8} (lane1 high).
- num_outputs=2 with inputs 0..5 (NUM_PE=1), ready dropped for 3 cycles after the 2nd request -> no rd_req while low; writes 8 then 3+8+15=26; exactly 6 requests total.
- Weight 0xFFFF, input 2, num_taps=1 -> output 0xFFFE (wrap modulo 2^16).
- Assert reset_n low during REQ of a 3-tap job -> all outputs 0 the same cycle. After release, restart with the same weights gives the correct result (8), confirming weights were retained.
- num_taps=0 -> done pulse one cycle after start, no pu_rd_req or pu_wr_req. A second start pulse while busy produces no extra job.
